// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_BITS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_read_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  input  logic [1:0]           cpu_width_i,
  input  logic                 cpu_sign_extend_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 mem_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 5;

  // S_RETURN is the extra stalled cycle after the fill lands, before the re-lookup
  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_RETURN} state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  logic [LINE_BITS-1:0]  r_data [LINES];
  logic [INDEX_BITS-1:0] r_miss_index;
  logic [TAG_BITS-1:0]   r_miss_tag;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [31:0]           r_mem_addr;
  logic [LINE_BITS-1:0]  r_mem_wdata;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_access;
  logic                  w_hit;
  logic                  w_store_hit;
  logic [LINE_BITS-1:0]  w_line;
  logic [LINE_BITS-1:0]  w_wmask;
  logic [LINE_BITS-1:0]  w_wline;
  logic [7:0]            w_shift;
  logic [31:0]           w_word;
  logic [31:0]           w_mask32;
  logic [31:0]           w_data32;
  logic [31:0]           w_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_index     = cpu_addr_i[INDEX_BITS+4:5];
  assign w_tag       = cpu_addr_i[31:INDEX_BITS+5];
  // Gating with rst_n keeps stall and load data quiet while reset is held
  assign w_access    = (cpu_read_i | cpu_write_i) & rst_n;
  assign w_line      = r_data[w_index];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_store_hit = (r_state == S_IDLE) && w_access && w_hit && cpu_write_i;
  assign w_shift     = {cpu_addr_i[4:2], 5'b00000};
  assign w_word      = w_line[w_shift +: 32];

  // Load path: pick byte/half/word from the addressed word and extend
  always_comb begin
    w_byte  = w_word[{cpu_addr_i[1:0], 3'b000} +: 8];
    w_half  = w_word[{cpu_addr_i[1], 4'b0000} +: 16];
    w_rdata = w_word;
    case (cpu_width_i)
      2'd0:    w_rdata = {{24{cpu_sign_extend_i & w_byte[7]}}, w_byte};
      2'd1:    w_rdata = {{16{cpu_sign_extend_i & w_half[15]}}, w_half};
      default: w_rdata = w_word;
    endcase
  end

  // Store path: build a lane mask and merge replicated store data into the line
  always_comb begin
    w_mask32 = '1;
    w_data32 = cpu_wdata_i;
    case (cpu_width_i)
      2'd0: begin
        w_mask32 = 32'h0000_00FF << {cpu_addr_i[1:0], 3'b000};
        w_data32 = {4{cpu_wdata_i[7:0]}};
      end
      2'd1: begin
        w_mask32 = 32'h0000_FFFF << {cpu_addr_i[1], 4'b0000};
        w_data32 = {2{cpu_wdata_i[15:0]}};
      end
      default: begin
        w_mask32 = '1;
        w_data32 = cpu_wdata_i;
      end
    endcase
    w_wmask = {{(LINE_BITS-32){1'b0}}, w_mask32} << w_shift;
    w_wline = (w_line & ~w_wmask) | ({(LINE_BITS/32){w_data32}} & w_wmask);
  end

  assign cpu_rdata_o = (w_access && w_hit) ? w_rdata : '0;
  assign mem_stall_o = (w_access && !w_hit && (r_state == S_IDLE)) || (r_state != S_IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  // Miss FSM with registered memory-side outputs, plus valid/dirty bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_miss_index <= '0;
      r_miss_tag   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && !w_hit) begin
            r_miss_index <= w_index;
            r_miss_tag   <= w_tag;
            r_mem_req    <= 1'b1;
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state     <= S_WRITEBACK;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_index], w_index, 5'b00000};
              r_mem_wdata <= w_line;
            end else begin
              r_state    <= S_ALLOCATE;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_index, 5'b00000};
            end
          end else if (w_store_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state     <= S_ALLOCATE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {r_miss_tag, r_miss_index, 5'b00000};
            r_mem_wdata <= '0;
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state               <= S_RETURN;
            r_mem_req             <= 1'b0;
            r_mem_addr            <= '0;
            r_valid[r_miss_index] <= 1'b1;
            r_dirty[r_miss_index] <= 1'b0;
          end
        end
        S_RETURN: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage and tags: filled on allocate ack, merged on store hit; not reset
  always_ff @(posedge clk) begin
    if ((r_state == S_ALLOCATE) && mem_ack_i) begin
      r_data[r_miss_index] <= mem_rdata_i;
      r_tag[r_miss_index]  <= r_miss_tag;
    end else if (w_store_hit) begin
      r_data[w_index] <= w_wline;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_read_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [1:0]   cpu_width_i;
  logic         cpu_sign_extend_i;
  logic [31:0]  cpu_rdata_o;
  logic         mem_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(4), .LINE_BITS(256)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_read_i        (cpu_read_i),
    .cpu_write_i       (cpu_write_i),
    .cpu_addr_i        (cpu_addr_i),
    .cpu_wdata_i       (cpu_wdata_i),
    .cpu_width_i       (cpu_width_i),
    .cpu_sign_extend_i (cpu_sign_extend_i),
    .cpu_rdata_o       (cpu_rdata_o),
    .mem_stall_o       (mem_stall_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_rdata_i       (mem_rdata_i),
    .mem_ack_i         (mem_ack_i)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  sb_q[$];
  logic [255:0] shadow [logic [31:0]];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (shadow.exists(la)) return shadow[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = (la + 32'(4*k)) ^ 32'hA500_0000;
    return l;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic sx);
    logic [255:0] l;
    logic [31:0]  wd;
    logic [7:0]   b;
    logic [15:0]  h;
    l  = get_line({a[31:5], 5'b0});
    wd = l[32*a[4:2] +: 32];
    b  = wd[8*a[1:0] +: 8];
    h  = wd[16*a[1] +: 16];
    if (w == 2'd0) return sx ? {{24{b[7]}}, b} : {24'b0, b};
    if (w == 2'd1) return sx ? {{16{h[15]}}, h} : {16'b0, h};
    return wd;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    logic [255:0] l;
    l = get_line({a[31:5], 5'b0});
    if (w == 2'd0)      l[8*a[4:0] +: 8]   = d[7:0];
    else if (w == 2'd1) l[16*a[4:1] +: 16] = d[15:0];
    else                l[32*a[4:2] +: 32] = d;
    shadow[{a[31:5], 5'b0}] = l;
  endfunction

  // One CPU access, acting as backing memory with fixed latencies while stalled
  task automatic access(input bit is_store, input logic [31:0] addr, input logic [1:0] width,
                        input logic sext, input logic [31:0] wdata, input bit exp_miss,
                        input bit exp_dirty, input logic [31:0] wb_addr, input int l_wb,
                        input int l_fill, input string tag);
    int stalls;
    int reqs;
    int phase;
    int exp_stalls;
    logic [31:0] la;
    la = {addr[31:5], 5'b0};
    if (!is_store) sb_q.push_back(model_load(addr, width, sext));
    @(negedge clk);
    cpu_read_i        = !is_store;
    cpu_write_i       = is_store;
    cpu_addr_i        = addr;
    cpu_wdata_i       = wdata;
    cpu_width_i       = width;
    cpu_sign_extend_i = sext;
    #1;
    stalls = 0;
    reqs   = 0;
    phase  = exp_dirty ? 0 : 1;
    for (int cyc = 0; cyc < 60 && mem_stall_o; cyc++) begin
      stalls++;
      if (mem_req_o) begin
        reqs++;
        check({tag, "_we"}, mem_we_o, phase == 0);
        check({tag, "_maddr"}, mem_addr_o, (phase == 0) ? wb_addr : la);
        if (phase == 0) check({tag, "_wbdata"}, mem_wdata_o, get_line(wb_addr));
        if (reqs == ((phase == 0) ? l_wb : l_fill)) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = (phase == 1) ? get_line(la) : '0;
          phase++;
          reqs = 0;
        end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
    end
    exp_stalls = !exp_miss ? 0 : (exp_dirty ? 2 + l_wb + l_fill : 2 + l_fill);
    check({tag, "_stalls"}, stalls, exp_stalls);
    if (exp_miss) check({tag, "_xfers_done"}, phase, 2);
    check({tag, "_req_low"}, mem_req_o, 1'b0);
    if (!is_store) check({tag, "_rdata"}, cpu_rdata_o, sb_q.pop_front());
    else model_store(addr, width, wdata);
    @(negedge clk);
    cpu_read_i  = 1'b0;
    cpu_write_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] l;
    rst_n = 1'b0;
    cpu_read_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h100; cpu_wdata_i = '0;
    cpu_width_i = 2'd2; cpu_sign_extend_i = 1'b0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   mem_req_o,   1'b0);
    check("rst_we",    mem_we_o,    1'b0);
    check("rst_addr",  mem_addr_o,  32'h0);
    check("rst_wdata", mem_wdata_o, 256'h0);
    check("rst_stall", mem_stall_o, 1'b0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    @(negedge clk);
    cpu_read_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("idle_stall", mem_stall_o, 1'b0);

    l = get_line(32'h100);
    l[31:0] = 32'hDEAD_BEEF;
    shadow[32'h100] = l;
    access(0, 32'h100, 2'd2, 0, 0, 1, 0, 0, 0, 3, "clean_miss");
    access(1, 32'h103, 2'd0, 0, 32'h80, 0, 0, 0, 0, 0, "st_byte");
    access(0, 32'h103, 2'd0, 1, 0, 0, 0, 0, 0, 0, "ld_byte_s");
    access(0, 32'h103, 2'd0, 0, 0, 0, 0, 0, 0, 0, "ld_byte_u");
    access(0, 32'h2100, 2'd2, 0, 0, 1, 1, 32'h100, 2, 1, "dirty_miss");
    access(0, 32'h100, 2'd2, 0, 0, 1, 0, 0, 0, 3, "clean_after_wb");
    access(1, 32'h202, 2'd1, 0, 32'h1234, 1, 0, 0, 0, 1, "st_half");
    access(0, 32'h200, 2'd2, 0, 0, 0, 0, 0, 0, 0, "ld_word_200");
    access(0, 32'h202, 2'd1, 0, 0, 0, 0, 0, 0, 0, "ld_half_202");

    @(negedge clk);
    cpu_read_i = 1'b1; cpu_addr_i = 32'h340; cpu_width_i = 2'd2;
    #1;
    check("rstmid_detect_stall", mem_stall_o, 1'b1);
    @(negedge clk);
    #1;
    check("rstmid_alloc_req", mem_req_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_req_drop",   mem_req_o,   1'b0);
    check("rstmid_stall_drop", mem_stall_o, 1'b0);
    @(negedge clk);
    cpu_read_i = 1'b0;
    rst_n = 1'b1;
    access(0, 32'h340, 2'd2, 0, 0, 1, 0, 0, 0, 2, "remiss_340");
    access(0, 32'h100, 2'd2, 0, 0, 1, 0, 0, 0, 1, "remiss_100");

    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_rdata_i = {8{32'hCAFE_F00D}};
    #1;
    check("stray_ack_stall", mem_stall_o, 1'b0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("stray_ack_req", mem_req_o, 1'b0);
    check("stray_ack_we",  mem_we_o,  1'b0);
    access(0, 32'h344, 2'd2, 0, 0, 0, 0, 0, 0, 0, "after_stray");
    access(0, 32'h346, 2'd1, 1, 0, 0, 0, 0, 0, 0, "after_stray_h");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
